// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encodings, parity selectors and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side request bus and serial-side outputs of the UART transmitter.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input TX_OUT, busy);
  modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_serializer.sv
// Latched shift register plus bit counter; o_bit is the next data bit to send.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_shift,
  input  logic                  i_count,
  input  logic                  i_clear,
  output logic                  o_bit,
  output logic                  o_done
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;

  assign o_bit  = r_shift[0];
  assign o_done = (r_cnt == CW'(DATA_WIDTH - 1));

  // Counter tracks the index of the bit currently on the line and never wraps.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else begin
      if (i_shift)
        r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      if (i_clear)
        r_cnt <= '0;
      else if (i_count && !o_done)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one frame bit per baud clock, registered line and busy outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);
  uart_state_e r_state, w_next;
  logic        r_tx, r_busy, r_par_en, r_par_bit;
  logic        w_tx_nxt, w_busy_nxt;
  logic        w_load, w_shift, w_count, w_clear;
  logic        w_bit, w_done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK     (CLK),
    .RST     (RST),
    .i_load  (w_load),
    .i_data  (bus.P_DATA),
    .i_shift (w_shift),
    .i_count (w_count),
    .i_clear (w_clear),
    .o_bit   (w_bit),
    .o_done  (w_done)
  );

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_count = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE:   if (bus.Data_Valid) begin
                   w_next = ST_START;
                   w_load = 1'b1;
                 end
      ST_START:  w_next = ST_DATA;
      ST_DATA:   if (w_done) begin
                   w_next  = r_par_en ? ST_PARITY : ST_STOP;
                   w_clear = 1'b1;
                 end else begin
                   w_count = 1'b1;
                 end
      ST_PARITY: w_next = ST_STOP;
      ST_STOP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they land with it.
  always_comb begin
    w_tx_nxt   = IDLE_LEVEL;
    w_busy_nxt = 1'b0;
    w_shift    = 1'b0;
    case (w_next)
      ST_START:  begin w_tx_nxt = START_LEVEL; w_busy_nxt = 1'b1; end
      ST_DATA:   begin w_tx_nxt = w_bit; w_busy_nxt = 1'b1; w_shift = 1'b1; end
      ST_PARITY: begin w_tx_nxt = r_par_bit; w_busy_nxt = 1'b1; end
      ST_STOP:   begin w_tx_nxt = IDLE_LEVEL; w_busy_nxt = 1'b1; end
      default:   begin w_tx_nxt = IDLE_LEVEL; w_busy_nxt = 1'b0; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      // Parity is fixed at accept since the shift register is consumed during DATA.
      if (w_load) begin
        r_par_en  <= bus.PAR_EN;
        r_par_bit <= (^bus.P_DATA) ^ bus.PAR_TYP;
      end
    end
  end

  assign bus.TX_OUT = r_tx;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames decoded by a simple RX model, plus reset and back-to-back sequences.
module tb_uart_tx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        mut;
    int          len;
    logic [11:0] exp_line;
    logic        exp_par;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_tx_if #(.DATA_WIDTH(8)) bus();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Line sample k is taken on the falling edge after the k-th rising edge from accept.
  task automatic run_frame(input vec_t v, output logic [11:0] line, output int bcnt);
    line = '0;
    bcnt = 0;
    @(negedge CLK);
    bus.P_DATA = v.data; bus.PAR_EN = v.pe; bus.PAR_TYP = v.pt; bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1 bus.Data_Valid = 1'b0;
    for (int k = 0; k <= v.len; k++) begin
      @(negedge CLK);
      line[k] = bus.TX_OUT;
      if (bus.busy) bcnt++;
      if (v.mut && k == 3) begin
        bus.P_DATA = ~v.data; bus.PAR_TYP = ~v.pt; bus.PAR_EN = ~v.pe; bus.Data_Valid = 1'b1;
      end
      if (v.mut && k == 4) bus.Data_Valid = 1'b0;
    end
  endtask

  vec_t        vt [7];
  logic [11:0] line;
  int          bcnt;
  int          bad;
  logic [23:0] cap;
  logic        b10;

  initial begin
    bus.P_DATA = '0; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;

    //          data   pe    pt    mut   len exp_line  exp_par
    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 12'h74A, 1'b0};
    vt[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 12'hD4A, 1'b0};
    vt[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, 12'hF4A, 1'b1};
    vt[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 11, 12'hE02, 1'b1};
    vt[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 11, 12'hE00, 1'b1};
    vt[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11, 12'hDFE, 1'b0};
    vt[6] = '{8'h3C, 1'b0, 1'b1, 1'b0, 10, 12'h678, 1'b0};

    #2 RST = 1'b0;
    #1;
    chk("rst_tx",   32'(bus.TX_OUT), 32'd1);
    chk("rst_busy", 32'(bus.busy),   32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_tx", 32'(bus.TX_OUT), 32'd1);

    // Asynchronous reset in the middle of DATA while the line is low.
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1 bus.Data_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid_tx",   32'(bus.TX_OUT), 32'd0);
    chk("mid_busy", 32'(bus.busy),   32'd1);
    #2 RST = 1'b0;
    #1;
    chk("arst_tx",   32'(bus.TX_OUT), 32'd1);
    chk("arst_busy", 32'(bus.busy),   32'd0);
    @(negedge CLK);
    RST = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge CLK);
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("post_rst_idle", 32'(bad), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vt[i], line, bcnt);
      chk($sformatf("v%0d_line", i), 32'(line), 32'(vt[i].exp_line));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vt[i].len));
      chk($sformatf("v%0d_rx_byte", i), 32'(line[8:1]), 32'(vt[i].data));
      if (vt[i].pe)
        chk($sformatf("v%0d_rx_parity", i), 32'(line[9]), 32'(vt[i].exp_par));
      bad = 0;
      repeat (vt[i].mut ? 12 : 2) begin
        @(negedge CLK);
        if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) bad++;
      end
      chk($sformatf("v%0d_after_idle", i), 32'(bad), 32'd0);
    end

    // Data_Valid held high: two frames separated by exactly one idle-high cycle.
    cap = '0;
    b10 = 1'b1;
    @(negedge CLK);
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1 bus.P_DATA = 8'hFF;
    for (int k = 0; k < 22; k++) begin
      @(negedge CLK);
      cap[k] = bus.TX_OUT;
      if (k == 10) b10 = bus.busy;
      if (k == 11) bus.Data_Valid = 1'b0;
    end
    chk("b2b_line",  32'(cap[21:0]),  32'h3FF6AA);
    chk("b2b_gap_busy", 32'(b10),     32'd0);
    chk("b2b_byte1", 32'(cap[8:1]),   32'h55);
    chk("b2b_byte2", 32'(cap[19:12]), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
